// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX between NUM_SRC sources, one WORDS_PER_PACKET-word packet per grant.
// Latency: pending->grant 1 cycle; accepted src_req -> uart_req/uart_data next cycle; >=3 cycles per word.
// Backpressure: src_uart_ready follows uart_ready for the granted source only; ARB_TIMEOUT_EN adds an idle-grant watchdog.
module uart_tx_arb #(
    parameter int NUM_SRC          = 2,
    parameter int WORD_SIZE        = 8,
    parameter int WORDS_PER_PACKET = 4,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SRC-1:0]             src_pending,
    input  logic [NUM_SRC*WORD_SIZE-1:0]   src_data,
    input  logic [NUM_SRC-1:0]             src_req,
    output logic [NUM_SRC-1:0]             src_uart_ready,
    output logic [NUM_SRC-1:0]             grant,
    input  logic                           uart_ready,
    output logic [WORD_SIZE-1:0]           uart_data,
    output logic                           uart_req,
    output logic                           timeout
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int CW = $clog2(WORDS_PER_PACKET + 1);
    localparam logic [IW:0] NS = (IW+1)'(NUM_SRC);

    typedef enum logic [1:0] {IDLE, LOCK, FWD, HOLD} state_t;

    state_t               state;
    logic [IW-1:0]        gidx;
    logic [IW-1:0]        last;
    logic [CW-1:0]        ctr;
    logic [IW-1:0]        pick;
    logic                 pick_vld;
    logic [IW:0]          sum;
    logic [WORD_SIZE-1:0] sel_word;
    logic                 accept;

`ifdef ARB_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TCW-1:0] tcnt;
`endif

    // Search starts one past the previous owner so every pending source gets a turn.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            sum = {1'b0, last} + (IW+1)'(k);
            if (sum >= NS) begin
                sum = sum - NS;
            end
            if (!pick_vld && src_pending[sum[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gidx == IW'(i)) begin
                sel_word = src_data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign accept         = src_req[gidx] && uart_ready;
    assign src_uart_ready = (state == LOCK && uart_ready) ? grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gidx      <= '0;
            last      <= IW'(NUM_SRC - 1);
            ctr       <= '0;
            grant     <= '0;
            uart_data <= '0;
            uart_req  <= 1'b0;
            timeout   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            uart_req <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gidx  <= pick;
                        grant <= NUM_SRC'(1) << pick;
                        ctr   <= '0;
`ifdef ARB_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        uart_data <= sel_word;
                        uart_req  <= 1'b1;
                        ctr       <= ctr + 1'b1;
`ifdef ARB_TIMEOUT_EN
                        tcnt      <= '0;
`endif
                        state     <= FWD;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                        timeout <= 1'b1;
                        grant   <= '0;
                        last    <= gidx;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                FWD: begin
                    state <= HOLD;
                end
                HOLD: begin
                    // The UART drops uart_ready right after the strobe, so this waits out the word.
                    if (uart_ready) begin
                        if (ctr == CW'(WORDS_PER_PACKET)) begin
                            grant <= '0;
                            last  <= gidx;
                            state <= IDLE;
                        end else begin
                            state <= LOCK;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus a randomized phase, all checked every cycle
// against a packet-level reference model; literal expectations pin the model on the directed runs.
module tb_uart_tx_arb;

    localparam int N   = 2;
    localparam int W   = 8;
    localparam int WPP = 4;
    localparam int TO  = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   src_pending = '0;
    logic [N*W-1:0] src_data = '0;
    logic [N-1:0]   src_req = '0;
    logic [N-1:0]   src_uart_ready;
    logic [N-1:0]   grant;
    logic           uart_ready = 1'b1;
    logic [W-1:0]   uart_data;
    logic           uart_req;
    logic           timeout;

    always #5 clk = ~clk;

    uart_tx_arb #(.NUM_SRC(N), .WORD_SIZE(W), .WORDS_PER_PACKET(WPP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .src_pending(src_pending), .src_data(src_data),
        .src_req(src_req), .src_uart_ready(src_uart_ready), .grant(grant),
        .uart_ready(uart_ready), .uart_data(uart_data), .uart_req(uart_req), .timeout(timeout)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: who owns the link, how many words it has sent, and where in a word's life we are.
    int           m_g, m_sent, m_last, m_idle;
    bit           m_open, m_strobe, m_wait, m_to;
    logic [W-1:0] m_data;

    task automatic model_reset();
        m_g = -1; m_sent = 0; m_last = N - 1; m_idle = 0;
        m_open = 0; m_strobe = 0; m_wait = 0; m_to = 0; m_data = '0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            cyc++;
            m_to = 0;
            if (m_g < 0) begin
                for (int k = 1; k <= N; k++)
                    if (m_g < 0 && src_pending[(m_last + k) % N]) m_g = (m_last + k) % N;
                if (m_g >= 0) begin m_sent = 0; m_open = 1; m_idle = 0; end
            end else if (m_open) begin
                if (src_req[m_g] && uart_ready) begin
                    m_data = src_data[m_g*W +: W];
                    m_sent++; m_open = 0; m_strobe = 1; m_idle = 0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (m_idle == TO - 1) begin
                    m_to = 1; m_last = m_g; m_g = -1; m_open = 0;
                end else begin
                    m_idle++;
                end
`endif
            end else if (m_strobe) begin
                m_strobe = 0; m_wait = 1;
            end else if (m_wait && uart_ready) begin
                m_wait = 0;
                if (m_sent == WPP) begin m_last = m_g; m_g = -1; end
                else m_open = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("grant", 32'(grant), (m_g < 0) ? 32'd0 : (32'd1 << m_g));
            check("uart_req", 32'(uart_req), 32'(m_strobe));
            check("uart_data", 32'(uart_data), 32'(m_data));
            check("timeout", 32'(timeout), 32'(m_to));
            check("src_uart_ready", 32'(src_uart_ready),
                  (m_open && uart_ready) ? (32'd1 << m_g) : 32'd0);
        end
    end

    // Observation log used by the literal checks.
    logic [W-1:0] obs[$];
    logic [N-1:0] obs_g[$];
    logic [N-1:0] gseq[$];
    int           scyc[$];
    logic [N-1:0] pg = '0;
    int           to_n = 0;
    int           to_cyc = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (uart_req) begin obs.push_back(uart_data); obs_g.push_back(grant); scyc.push_back(cyc); end
            if (grant != pg && grant != '0) gseq.push_back(grant);
            if (timeout) begin to_n++; to_cyc = cyc; end
        end
        pg = reset ? '0 : grant;
    end

    // Source and UART drivers.
    bit [N-1:0]   want = '0;
    bit [N-1:0]   noise = '0;
    bit           rdy_rand = 0;
    logic [W-1:0] noise_dat = 8'hAA;
    int           bmin = 2, bmax = 5, busy = 0;
    logic [W-1:0] tbl[N][8];
    int           acc[N];

    always @(posedge clk) begin
        #1;
        if (reset) begin
            busy = 0; uart_ready = 1'b1; src_req = '0;
            for (int i = 0; i < N; i++) acc[i] = 0;
        end else begin
            if (uart_req) begin
                uart_ready = 1'b0;
                busy = $urandom_range(bmax, bmin);
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) uart_ready = 1'b1;
            end else begin
                uart_ready = rdy_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (want[i] && src_uart_ready[i]) begin
                    src_req[i] = 1'b1;
                    src_data[i*W +: W] = tbl[i][acc[i] % 8];
                    acc[i]++;
                end else if (noise[i]) begin
                    src_req[i] = 1'($urandom_range(1, 0));
                    src_data[i*W +: W] = noise_dat;
                end else begin
                    src_req[i] = 1'b0;
                    src_data[i*W +: W] = W'($urandom);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        obs.delete(); obs_g.delete(); gseq.delete(); scyc.delete(); to_n = 0;
        reset = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int t;
        t = 0;
        while (obs.size() < n && t < budget) begin @(negedge clk); t++; end
        vectors++;
        if (obs.size() < n) begin
            errors++;
            $display("FAIL wait_words: got %0d words, want %0d", obs.size(), n);
        end
    endtask

    task automatic fill_tbl();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 8; j++) tbl[i][j] = W'($urandom_range(8'hA9, 0));
    endtask

    logic [W-1:0] t1_exp[4];
    logic [N-1:0] eg;
    int           n_aa;

    initial begin
        t1_exp[0] = 8'h11; t1_exp[1] = 8'h22; t1_exp[2] = 8'h33; t1_exp[3] = 8'h44;
        fill_tbl();

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_uart_req", 32'(uart_req), 0);
        check("rst_uart_data", 32'(uart_data), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_src_uart_ready", 32'(src_uart_ready), 0);
        @(negedge clk) reset = 1'b0;

        // Single source, fixed words.
        for (int j = 0; j < 4; j++) tbl[0][j] = t1_exp[j];
        want = 2'b01; src_pending = 2'b01;
        wait_words(4, 200);
        src_pending = 2'b00;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 4; k++) check("t1_word", 32'(obs[k]), 32'(t1_exp[k]));
        check("t1_grant_idle", 32'(grant), 0);

        // Contention: packets alternate and never interleave.
        fill_tbl();
        do_reset();
        want = 2'b11; src_pending = 2'b11;
        wait_words(16, 400);
        for (int k = 0; k < 4; k++) begin
            eg = (k % 2 == 1) ? 2'b10 : 2'b01;
            check("t2_grant_order", 32'(gseq[k]), 32'(eg));
        end
        for (int k = 0; k < 16; k++) begin
            eg = ((k / 4) % 2 == 1) ? 2'b10 : 2'b01;
            check("t2_word_owner", 32'(obs_g[k]), 32'(eg));
        end
        src_pending = 2'b00;

        // Requests from a source that does not own the link are dropped.
        do_reset();
        noise_dat = 8'hAA; noise = 2'b10; want = 2'b01; src_pending = 2'b01;
        wait_words(8, 300);
        n_aa = 0;
        foreach (obs[k]) if (obs[k] == 8'hAA) n_aa++;
        check("t3_no_aa_words", 32'(n_aa), 0);
        noise = 2'b00; src_pending = 2'b00;

        // Slow UART: ready held low 20 cycles after every strobe.
        do_reset();
        bmin = 20; bmax = 20; want = 2'b01; src_pending = 2'b01;
        wait_words(3, 200);
        check("t4_gap1", 32'(scyc[1] - scyc[0]), 22);
        check("t4_gap2", 32'(scyc[2] - scyc[1]), 22);
        src_pending = 2'b00; bmin = 2; bmax = 5;
        repeat (25) @(negedge clk);

        // Reset in the middle of a packet.
        do_reset();
        want = 2'b11; src_pending = 2'b11;
        wait_words(2, 100);
        #1 reset = 1'b1;
        #1;
        check("t5_grant", 32'(grant), 0);
        check("t5_uart_req", 32'(uart_req), 0);
        check("t5_uart_data", 32'(uart_data), 0);
        check("t5_src_uart_ready", 32'(src_uart_ready), 0);
        check("t5_timeout", 32'(timeout), 0);
        @(negedge clk);
        obs.delete(); obs_g.delete(); gseq.delete(); scyc.delete();
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_first_grant", 32'(gseq[0]), 32'(2'b01));
        src_pending = 2'b00;
        repeat (40) @(negedge clk);

        // Stalled owner: watchdog revokes the grant, or the grant persists without it.
        do_reset();
        bmin = 2; bmax = 2; want = 2'b01; src_pending = 2'b11;
        wait_words(1, 50);
        want = 2'b10;
`ifdef ARB_TIMEOUT_EN
        for (int t = 0; t < 60 && to_n == 0; t++) @(negedge clk);
        check("t6_timeout_seen", 32'(to_n), 1);
        check("t6_timeout_delay", 32'(to_cyc - scyc[0]), 19);
        repeat (3) @(negedge clk);
        check("t6_next_grant", 32'(gseq[1]), 32'(2'b10));
`else
        repeat (60) @(negedge clk);
        check("t6_grant_held", 32'(grant), 32'(2'b01));
        check("t6_no_timeout", 32'(to_n), 0);
`endif
        src_pending = 2'b00; bmin = 2; bmax = 5;

        // Randomized traffic against the model.
        do_reset();
        rdy_rand = 1; noise = 2'b11;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            noise_dat = W'($urandom);
            if ($urandom_range(15, 0) == 0) src_pending = N'($urandom);
            if ($urandom_range(31, 0) == 0) want = N'($urandom);
        end
        src_pending = '0; want = '1; noise = '0;
        repeat (100) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
